// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for the UART RX path.
// Detects the start edge, runs the tick/bit counters used by the data sampler,
// deserializes the majority-voted bits LSB first and checks parity and stop bits.
// A good frame updates P_DATA with a one-cycle data_valid pulse; a bad frame
// produces a one-cycle par_err or stp_err pulse and is dropped.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  S_RX_IN,
  input  logic [5:0]            prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  data_samp_en,
  output logic [4:0]            edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Only these oversampling rates keep edge_cnt inside its 5-bit range with a
  // well-defined mid-bit sampling point.
  function automatic logic prescale_ok(input logic [5:0] p);
    logic ok;
    case (p)
      6'd8, 6'd16, 6'd32: ok = 1'b1;
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Parity bit the transmitter should have sent: even parity makes the total
  // number of ones even, odd parity inverts that.
  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d,
                                           input logic                  odd);
    return (^d) ^ odd;
  endfunction

  state_e                state_q,      state_d;
  logic [4:0]            edge_cnt_q,   edge_cnt_d;
  logic [3:0]            bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q,      shreg_d;
  logic [DATA_WIDTH-1:0] p_data_q,     p_data_d;
  logic [5:0]            prescale_l_q, prescale_l_d;
  logic                  par_en_l_q,   par_en_l_d;
  logic                  par_typ_l_q,  par_typ_l_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q,    par_err_d;
  logic                  stp_err_q,    stp_err_d;
  logic                  busy_q,       busy_d;
  logic                  samp_en_q,    samp_en_d;
  logic                  bit_end_s;

  // Bit end: last tick of the current bit, using the prescale latched at frame start.
  always_comb begin
    bit_end_s = 1'b0;
    if ((state_q != ST_IDLE) && ({1'b0, edge_cnt_q} == (prescale_l_q - 6'd1))) begin
      bit_end_s = 1'b1;
    end else begin
      bit_end_s = 1'b0;
    end
  end

  // Next-state, counter, shift register and pulse logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    p_data_d     = p_data_q;
    prescale_l_d = prescale_l_q;
    par_en_l_d   = par_en_l_q;
    par_typ_l_d  = par_typ_l_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    // Tick counting is common to every active state.
    if (state_q != ST_IDLE) begin
      if (bit_end_s) begin
        edge_cnt_d = 5'd0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
      end else begin
        edge_cnt_d = edge_cnt_q + 5'd1;
      end
    end else begin
      edge_cnt_d = 5'd0;
      bit_cnt_d  = 4'd0;
    end

    case (state_q)
      ST_IDLE: begin
        // A low line is a start candidate only at a supported rate; the
        // configuration is frozen here for the whole frame.
        if (!S_RX_IN && prescale_ok(prescale)) begin
          prescale_l_d = prescale;
          par_en_l_d   = PAR_EN;
          par_typ_l_d  = PAR_TYP;
          shreg_d      = '0;
          state_d      = ST_START;
        end else begin
          state_d      = ST_IDLE;
        end
      end

      ST_START: begin
        if (bit_end_s) begin
          // A start bit that votes high was a glitch: drop it silently.
          if (sampled_bit) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
          end else begin
            state_d   = ST_DATA;
          end
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (bit_end_s) begin
          // bit_cnt 1..DATA_WIDTH maps onto shreg[0..DATA_WIDTH-1], LSB first.
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt_q == 4'(i + 1)) begin
              shreg_d[i] = sampled_bit;
            end else begin
              shreg_d[i] = shreg_q[i];
            end
          end
          if (bit_cnt_q == 4'(DATA_WIDTH)) begin
            if (par_en_l_q) begin
              state_d = ST_PARITY;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_PARITY: begin
        if (bit_end_s) begin
          // On a parity mismatch the frame is abandoned without waiting for stop.
          if (sampled_bit != expected_parity(shreg_q, par_typ_l_q)) begin
            par_err_d = 1'b1;
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
          end else begin
            state_d   = ST_STOP;
          end
        end else begin
          state_d = ST_PARITY;
        end
      end

      ST_STOP: begin
        if (bit_end_s) begin
          if (sampled_bit) begin
            p_data_d     = shreg_q;
            data_valid_d = 1'b1;
          end else begin
            stp_err_d    = 1'b1;
          end
          state_d   = ST_IDLE;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = ST_STOP;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        edge_cnt_d = 5'd0;
        bit_cnt_d  = 4'd0;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    samp_en_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      edge_cnt_q   <= 5'd0;
      bit_cnt_q    <= 4'd0;
      shreg_q      <= '0;
      p_data_q     <= '0;
      prescale_l_q <= 6'd0;
      par_en_l_q   <= 1'b0;
      par_typ_l_q  <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      samp_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      p_data_q     <= p_data_d;
      prescale_l_q <= prescale_l_d;
      par_en_l_q   <= par_en_l_d;
      par_typ_l_q  <= par_typ_l_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
      samp_en_q    <= samp_en_d;
    end
  end

  assign data_samp_en = samp_en_q;
  assign edge_cnt     = edge_cnt_q;
  assign bit_cnt      = bit_cnt_q;
  assign P_DATA       = p_data_q;
  assign data_valid   = data_valid_q;
  assign par_err      = par_err_q;
  assign stp_err      = stp_err_q;
  assign busy         = busy_q;

endmodule
